// File: rtl/maple_out.sv
// maple_out: Maple bus transmitter. Serializes bytes from a valid/ready source
// onto SDCKA (pin1) and SDCKB (pin5). The frame is a start pattern, then data
// bits whose clock line alternates between the two pins, then an optional XOR
// checksum byte, then the end pattern, followed by an idle gap with the bus released.
module maple_out #(
    parameter int PHASE_CLKS   = 9,
    parameter int GAP_CLKS     = 54,
    parameter int ADD_CHECKSUM = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       pin1_out,
    output logic       pin5_out,
    output logic       oe,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam int PW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_END   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] ph_cnt;     // clk count within the current line phase
    logic [3:0]    step;       // phase index within START / END
    logic [2:0]    bit_cnt;    // bit index within the byte, 0 = MSB
    logic [1:0]    sub;        // phase within a bit: 0 = a, 1 = b, 2 = c
    logic [GW-1:0] gap_cnt;
    logic [7:0]    hold_data;
    logic [7:0]    shift;
    logic [7:0]    checksum;
    logic          hold_full;
    logic          hold_last;
    logic          last_acc;   // final payload byte already accepted
    logic          cur_last;   // byte in the shift register is the final payload byte
    logic          send_ck;    // byte in the shift register is the checksum
    logic          armed;      // keeps tx_ready low for the first cycle after reset
    logic          hs;
    logic          phase_end;
    logic          byte_end;
    logic          gap_done;
    logic          load_hold;
    logic          data_clk;

    assign phase_end = (ph_cnt == PW'(PHASE_CLKS - 1));
    assign byte_end  = (state == S_DATA) && phase_end && (sub == 2'd2) && (bit_cnt == 3'd7);
    assign gap_done  = (gap_cnt == GW'(GAP_CLKS - 1));
    assign load_hold = ((state == S_START) && phase_end && (step == 4'd9)) ||
                       (byte_end && !send_ck && !cur_last && hold_full);
    assign tx_ready  = armed && !hold_full && !last_acc &&
                       ((state == S_IDLE) || (state == S_START) || (state == S_DATA));
    assign hs        = tx_valid && tx_ready;
    assign busy      = (state != S_IDLE);
    assign oe        = (state == S_START) || (state == S_DATA) || (state == S_END);

    // Phase timebase: free-runs 0..PHASE_CLKS-1 while a frame is on the wire.
    always_ff @(posedge clk) begin
        if (!reset_n || state == S_IDLE || state == S_GAP || phase_end) begin
            ph_cnt <= '0;
        end else begin
            ph_cnt <= ph_cnt + 1'b1;
        end
    end

    // Holding register and running checksum; a handshake wins over a drain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            hold_last <= 1'b0;
            last_acc  <= 1'b0;
            checksum  <= '0;
            armed     <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (hs) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
                hold_last <= tx_last;
                checksum  <= checksum ^ tx_data;
                if (tx_last) begin
                    last_acc <= 1'b1;
                end
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
            if (state == S_GAP && gap_done) begin
                checksum <= '0;
                last_acc <= 1'b0;
            end
        end
    end

    // Frame sequencer: start pattern, data bytes, checksum, end pattern, gap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            step       <= '0;
            bit_cnt    <= '0;
            sub        <= '0;
            gap_cnt    <= '0;
            shift      <= '0;
            cur_last   <= 1'b0;
            send_ck    <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        state   <= S_START;
                        step    <= '0;
                        send_ck <= 1'b0;
                    end
                end
                S_START: begin
                    if (phase_end) begin
                        if (step == 4'd9) begin
                            state    <= S_DATA;
                            shift    <= hold_data;
                            cur_last <= hold_last;
                            bit_cnt  <= '0;
                            sub      <= '0;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (phase_end) begin
                        if (sub != 2'd2) begin
                            sub <= sub + 2'd1;
                        end else begin
                            sub <= '0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shift   <= {shift[6:0], 1'b0};
                            end else begin
                                bit_cnt <= '0;
                                if (send_ck) begin
                                    state <= S_END;
                                    step  <= '0;
                                end else if (cur_last) begin
                                    if (ADD_CHECKSUM != 0) begin
                                        shift   <= checksum;
                                        send_ck <= 1'b1;
                                    end else begin
                                        state <= S_END;
                                        step  <= '0;
                                    end
                                end else if (hold_full) begin
                                    shift    <= hold_data;
                                    cur_last <= hold_last;
                                end else begin
                                    underrun <= 1'b1;
                                    state    <= S_END;
                                    step     <= '0;
                                end
                            end
                        end
                    end
                end
                S_END: begin
                    if (phase_end) begin
                        if (step == 4'd5) begin
                            state      <= S_GAP;
                            gap_cnt    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        state    <= S_IDLE;
                        cur_last <= 1'b0;
                        send_ck  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line drive: decoded directly from the sequencer position.
    always_comb begin
        pin1_out = 1'b1;
        pin5_out = 1'b1;
        data_clk = (sub != 2'd1);
        case (state)
            S_START: begin
                if (step == 4'd0) begin
                    pin1_out = 1'b0;
                end else if (step != 4'd9) begin
                    pin1_out = 1'b0;
                    pin5_out = ~step[0];
                end
            end
            S_DATA: begin
                if (!bit_cnt[0]) begin
                    pin1_out = data_clk;
                    pin5_out = shift[7];
                end else begin
                    pin1_out = shift[7];
                    pin5_out = data_clk;
                end
            end
            S_END: begin
                if (step == 4'd0) begin
                    pin5_out = 1'b0;
                end else if (step != 4'd5) begin
                    pin1_out = ~step[0];
                    pin5_out = 1'b0;
                end
            end
            default: begin
                pin1_out = 1'b1;
                pin5_out = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_maple_out.sv
// tb_maple_out: drives frames into two maple_out instances (with and without
// checksum), records the bus cycle by cycle, decodes it phase by phase and
// checks decoded bytes against a scoreboard filled by the driver.
module tb_maple_out;
    localparam int PH  = 9;
    localparam int GAP = 54;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid_a, tx_valid_b;
    logic       ready_a, p1_a, p5_a, oe_a, busy_a, fd_a, ur_a;
    logic       ready_b, p1_b, p5_b, oe_b, busy_b, fd_b, ur_b;

    maple_out #(.PHASE_CLKS(PH), .GAP_CLKS(GAP), .ADD_CHECKSUM(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid_a),
        .tx_last(tx_last), .tx_ready(ready_a), .pin1_out(p1_a), .pin5_out(p5_a),
        .oe(oe_a), .busy(busy_a), .frame_done(fd_a), .underrun(ur_a));

    maple_out #(.PHASE_CLKS(PH), .GAP_CLKS(GAP), .ADD_CHECKSUM(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid_b),
        .tx_last(tx_last), .tx_ready(ready_b), .pin1_out(p1_b), .pin5_out(p5_b),
        .oe(oe_b), .busy(busy_b), .frame_done(fd_b), .underrun(ur_b));

    int   sel;
    logic m_ready, m_p1, m_p5, m_oe, m_busy, m_fd, m_ur;

    // Observe whichever instance the current test targets.
    always_comb begin
        if (sel == 0) begin
            m_ready = ready_a; m_p1 = p1_a; m_p5 = p5_a; m_oe = oe_a;
            m_busy = busy_a; m_fd = fd_a; m_ur = ur_a;
        end else begin
            m_ready = ready_b; m_p1 = p1_b; m_p5 = p5_b; m_oe = oe_b;
            m_busy = busy_b; m_fd = fd_b; m_ur = ur_b;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [8:0] drv_q[$];
    int         hs_t[$];
    logic [1:0] cyc_q[$];
    logic [1:0] ph_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] mask_q[$];
    int         t_fd, t_ur, fd_cnt, ur_cnt, busy_after_fd, cap_to;
    int         ph_err, shape_err, start_pulses, end_pulses;
    logic [3:0] p1_bits, p5_bits;

    task automatic set_valid(input logic v);
        if (sel == 0) tx_valid_a = v;
        else tx_valid_b = v;
    endtask

    // Presents every queued byte back to back and logs each accepted byte
    // (plus the model checksum on the checksum-enabled instance).
    task automatic drive_frame();
        logic [7:0] ck;
        logic [8:0] it;
        int n;
        ck = '0;
        hs_t.delete();
        while (drv_q.size() > 0) begin
            it = drv_q.pop_front();
            @(posedge clk); #1;
            tx_data = it[7:0];
            tx_last = it[8];
            set_valid(1'b1);
            n = 0;
            forever begin
                @(negedge clk);
                if (m_ready) break;
                n++;
                if (n > 4000) break;
            end
            if (n > 4000) begin
                vec_cnt++; err_cnt++;
                $display("FAIL handshake_timeout: got no tx_ready exp tx_ready within 4000 cycles");
                drv_q.delete();
                break;
            end
            hs_t.push_back(cyc);
            exp_q.push_back(it[7:0]);
            ck = ck ^ it[7:0];
            if (it[8] && sel == 0) exp_q.push_back(ck);
        end
        @(posedge clk); #1;
        set_valid(1'b0);
        tx_last = 1'b0;
    endtask

    // Records line values while oe is high and event pulses until busy drops.
    // Cycle 0 is the first START cycle.
    task automatic capture_frame();
        int n, t;
        cyc_q.delete();
        t_fd = -1; t_ur = -1; fd_cnt = 0; ur_cnt = 0; busy_after_fd = 0; cap_to = 0;
        n = 0;
        @(negedge clk);
        while (!m_oe) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin cap_to = 1; return; end
        end
        t = 0;
        while (m_busy) begin
            if (m_oe) cyc_q.push_back({m_p1, m_p5});
            if (m_fd) begin fd_cnt++; if (t_fd < 0) t_fd = t; end
            if (m_ur) begin ur_cnt++; if (t_ur < 0) t_ur = t; end
            if (t_fd >= 0) busy_after_fd++;
            @(negedge clk);
            t++;
            if (t > 6000) begin cap_to = 1; return; end
        end
    endtask

    // Bus-model receiver: folds cycles into phases, checks the start/end
    // patterns and recovers each bit at the falling edge of its clock line.
    task automatic decode_frame();
        int np, e, base;
        logic [1:0] a, b, c;
        logic [7:0] byt, msk;
        logic d;
        ph_q.delete(); rx_q.delete(); mask_q.delete();
        ph_err = 0; shape_err = 0; start_pulses = 0; end_pulses = 0;
        p1_bits = '0; p5_bits = '0;
        if (cyc_q.size() % PH != 0) ph_err++;
        for (int i = 0; i + PH <= cyc_q.size(); i += PH) begin
            for (int j = 1; j < PH; j++) if (cyc_q[i+j] !== cyc_q[i]) ph_err++;
            ph_q.push_back(cyc_q[i]);
        end
        np = ph_q.size();
        if (np < 16 || (np - 16) % 24 != 0) begin shape_err++; return; end
        if (ph_q[0] !== 2'b01 || ph_q[9] !== 2'b11) shape_err++;
        for (int i = 1; i <= 8; i++) begin
            if (ph_q[i][1] !== 1'b0) shape_err++;
            if (ph_q[i][0] == 1'b0 && ph_q[i-1][0] == 1'b1) start_pulses++;
        end
        e = np - 6;
        if (ph_q[e] !== 2'b10 || ph_q[e+5] !== 2'b11) shape_err++;
        for (int i = e + 1; i <= e + 4; i++) begin
            if (ph_q[i][0] !== 1'b0) shape_err++;
            if (ph_q[i][1] == 1'b0 && ph_q[i-1][1] == 1'b1) end_pulses++;
        end
        for (int k = 0; k < (np - 16) / 24; k++) begin
            byt = '0; msk = '0;
            for (int bi = 0; bi < 8; bi++) begin
                base = 10 + 24 * k + 3 * bi;
                a = ph_q[base]; b = ph_q[base+1]; c = ph_q[base+2];
                d = 1'b0;
                if (a[1] && !b[1] && c[1] && a[0] == b[0] && b[0] == c[0]) begin
                    d = b[0];
                    msk = {msk[6:0], 1'b1};
                    if (k == 0) p1_bits = {p1_bits[2:0], d};
                end else if (a[0] && !b[0] && c[0] && a[1] == b[1] && b[1] == c[1]) begin
                    d = b[1];
                    msk = {msk[6:0], 1'b0};
                    if (k == 0) p5_bits = {p5_bits[2:0], d};
                end else begin
                    shape_err++;
                    msk = {msk[6:0], 1'bx};
                end
                byt = {byt[6:0], d};
            end
            rx_q.push_back(byt);
            mask_q.push_back(msk);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset_n = 1'b0; tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_data = '0; tx_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (m_p1 !== 1'b1) begin err_cnt++; $display("FAIL rst_pin1: got %b exp 1", m_p1); end
        vec_cnt++; if (m_p5 !== 1'b1) begin err_cnt++; $display("FAIL rst_pin5: got %b exp 1", m_p5); end
        vec_cnt++; if (m_oe !== 1'b0) begin err_cnt++; $display("FAIL rst_oe: got %b exp 0", m_oe); end
        vec_cnt++; if (m_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b exp 0", m_busy); end
        vec_cnt++; if (m_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b exp 0", m_ready); end
        vec_cnt++; if (m_fd !== 1'b0 || m_ur !== 1'b0) begin err_cnt++; $display("FAIL rst_pulses: got fd=%b ur=%b exp 0/0", m_fd, m_ur); end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int n, fd_seen, oe_seen;
        sel = 0;
        drv_q.push_back({1'b1, 8'h55});
        drive_frame();
        n = 0;
        while (!m_oe && n < 100) begin @(negedge clk); n++; end
        vec_cnt++; if (n >= 100) begin err_cnt++; $display("FAIL mid_start: got oe=0 exp oe=1 within 100 cycles"); end
        repeat (150) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        vec_cnt++; if ({m_p1, m_p5} !== 2'b11) begin err_cnt++; $display("FAIL mid_lines: got %b exp 11", {m_p1, m_p5}); end
        vec_cnt++; if (m_oe !== 1'b0) begin err_cnt++; $display("FAIL mid_oe: got %b exp 0", m_oe); end
        vec_cnt++; if (m_busy !== 1'b0) begin err_cnt++; $display("FAIL mid_busy: got %b exp 0", m_busy); end
        vec_cnt++; if (m_ready !== 1'b0) begin err_cnt++; $display("FAIL mid_ready: got %b exp 0", m_ready); end
        fd_seen = 0; oe_seen = 0;
        if (m_fd) fd_seen++;
        repeat (400) begin
            @(negedge clk);
            if (m_fd) fd_seen++;
            if (m_oe) oe_seen++;
        end
        vec_cnt++; if (fd_seen != 0) begin err_cnt++; $display("FAIL mid_no_done: got %0d pulses exp 0", fd_seen); end
        vec_cnt++; if (oe_seen != 0) begin err_cnt++; $display("FAIL mid_no_end: got %0d oe cycles exp 0", oe_seen); end
        exp_q.delete();
    endtask

    task automatic test_controller_reply();
        logic [7:0] got, ex;
        sel = 0;
        drv_q.push_back({1'b0, 8'h03});
        drv_q.push_back({1'b0, 8'h20});
        drv_q.push_back({1'b0, 8'h00});
        drv_q.push_back({1'b1, 8'h08});
        fork
            drive_frame();
            capture_frame();
        join
        decode_frame();
        vec_cnt++; if (cap_to != 0) begin err_cnt++; $display("FAIL reply_timeout: got timeout exp frame"); end
        vec_cnt++; if (ph_err != 0 || shape_err != 0) begin err_cnt++; $display("FAIL reply_shape: got ph_err=%0d shape_err=%0d exp 0/0", ph_err, shape_err); end
        vec_cnt++; if (cyc_q.size() != PH * (16 + 24 * 5)) begin err_cnt++; $display("FAIL reply_len: got %0d exp %0d", cyc_q.size(), PH * (16 + 24 * 5)); end
        vec_cnt++; if (t_fd != PH * 10 + PH * 24 * 5 + PH * 6) begin err_cnt++; $display("FAIL reply_done_time: got %0d exp %0d", t_fd, PH * 136); end
        vec_cnt++; if (fd_cnt != 1 || ur_cnt != 0) begin err_cnt++; $display("FAIL reply_pulses: got fd=%0d ur=%0d exp 1/0", fd_cnt, ur_cnt); end
        vec_cnt++; if (busy_after_fd != GAP) begin err_cnt++; $display("FAIL reply_gap: got %0d exp %0d", busy_after_fd, GAP); end
        vec_cnt++; if (rx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL reply_count: got %0d exp %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); ex = exp_q.pop_front();
            vec_cnt++; if (got !== ex) begin err_cnt++; $display("FAIL reply_byte: got %h exp %h", got, ex); end
        end
        exp_q.delete();
    endtask

    task automatic test_start_end();
        logic [7:0] got, ex;
        sel = 1;
        drv_q.push_back({1'b1, 8'hFF});
        fork
            drive_frame();
            capture_frame();
        join
        decode_frame();
        vec_cnt++; if (cap_to != 0 || ph_err != 0 || shape_err != 0) begin err_cnt++; $display("FAIL se_shape: got to=%0d ph=%0d shape=%0d exp 0/0/0", cap_to, ph_err, shape_err); end
        vec_cnt++; if (start_pulses != 4) begin err_cnt++; $display("FAIL se_start_pulses: got %0d exp 4", start_pulses); end
        vec_cnt++; if (end_pulses != 2) begin err_cnt++; $display("FAIL se_end_pulses: got %0d exp 2", end_pulses); end
        vec_cnt++; if (cyc_q.size() != PH * (10 + 24 + 6)) begin err_cnt++; $display("FAIL se_len: got %0d exp %0d", cyc_q.size(), PH * 40); end
        vec_cnt++; if (t_fd != PH * 40) begin err_cnt++; $display("FAIL se_done_time: got %0d exp %0d", t_fd, PH * 40); end
        vec_cnt++; if (rx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL se_count: got %0d exp %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); ex = exp_q.pop_front();
            vec_cnt++; if (got !== ex) begin err_cnt++; $display("FAIL se_byte: got %h exp %h", got, ex); end
        end
        exp_q.delete();
        sel = 0;
    endtask

    task automatic test_bit_alternation();
        logic [7:0] got, ex;
        sel = 0;
        drv_q.push_back({1'b1, 8'hA5});
        fork
            drive_frame();
            capture_frame();
        join
        decode_frame();
        vec_cnt++; if (cap_to != 0 || shape_err != 0) begin err_cnt++; $display("FAIL alt_shape: got to=%0d shape=%0d exp 0/0", cap_to, shape_err); end
        vec_cnt++; if (mask_q.size() < 1 || mask_q[0] !== 8'hAA) begin err_cnt++; $display("FAIL alt_clock_lines: got %h exp aa", (mask_q.size() > 0) ? mask_q[0] : 8'h00); end
        vec_cnt++; if (p1_bits !== 4'b1100) begin err_cnt++; $display("FAIL alt_pin1_bits: got %b exp 1100", p1_bits); end
        vec_cnt++; if (p5_bits !== 4'b0011) begin err_cnt++; $display("FAIL alt_pin5_bits: got %b exp 0011", p5_bits); end
        vec_cnt++; if (rx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL alt_count: got %0d exp %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); ex = exp_q.pop_front();
            vec_cnt++; if (got !== ex) begin err_cnt++; $display("FAIL alt_byte: got %h exp %h", got, ex); end
        end
        exp_q.delete();
    endtask

    task automatic test_underrun();
        logic [7:0] got, ex;
        sel = 0;
        drv_q.push_back({1'b0, 8'h01});
        fork
            drive_frame();
            capture_frame();
        join
        decode_frame();
        vec_cnt++; if (cap_to != 0 || shape_err != 0) begin err_cnt++; $display("FAIL ur_shape: got to=%0d shape=%0d exp 0/0", cap_to, shape_err); end
        vec_cnt++; if (ur_cnt != 1) begin err_cnt++; $display("FAIL ur_pulse_count: got %0d exp 1", ur_cnt); end
        vec_cnt++; if (t_ur != PH * (10 + 24)) begin err_cnt++; $display("FAIL ur_time: got %0d exp %0d", t_ur, PH * 34); end
        vec_cnt++; if (fd_cnt != 1 || t_fd != PH * 40) begin err_cnt++; $display("FAIL ur_done: got n=%0d t=%0d exp 1/%0d", fd_cnt, t_fd, PH * 40); end
        vec_cnt++; if (rx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL ur_count: got %0d exp %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); ex = exp_q.pop_front();
            vec_cnt++; if (got !== ex) begin err_cnt++; $display("FAIL ur_byte: got %h exp %h", got, ex); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, ex;
        int d;
        sel = 0;
        drv_q.push_back({1'b0, 8'h11});
        drv_q.push_back({1'b0, 8'h22});
        drv_q.push_back({1'b0, 8'h33});
        drv_q.push_back({1'b0, 8'h44});
        drv_q.push_back({1'b1, 8'h55});
        fork
            drive_frame();
            capture_frame();
        join
        decode_frame();
        vec_cnt++; if (cap_to != 0 || ph_err != 0 || shape_err != 0) begin err_cnt++; $display("FAIL b2b_shape: got to=%0d ph=%0d shape=%0d exp 0/0/0", cap_to, ph_err, shape_err); end
        vec_cnt++; if (hs_t.size() != 5) begin err_cnt++; $display("FAIL b2b_accepts: got %0d exp 5", hs_t.size()); end
        for (int k = 1; k < hs_t.size(); k++) begin
            d = hs_t[k] - hs_t[k-1];
            vec_cnt++;
            if (d != ((k == 1) ? PH * 10 + 1 : PH * 24)) begin
                err_cnt++; $display("FAIL b2b_accept_spacing[%0d]: got %0d exp %0d", k, d, (k == 1) ? PH * 10 + 1 : PH * 24);
            end
        end
        vec_cnt++; if (cyc_q.size() != PH * (16 + 24 * 6)) begin err_cnt++; $display("FAIL b2b_len: got %0d exp %0d", cyc_q.size(), PH * 160); end
        vec_cnt++; if (busy_after_fd != GAP) begin err_cnt++; $display("FAIL b2b_gap: got %0d exp %0d", busy_after_fd, GAP); end
        vec_cnt++; if (rx_q.size() != exp_q.size()) begin err_cnt++; $display("FAIL b2b_count: got %0d exp %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); ex = exp_q.pop_front();
            vec_cnt++; if (got !== ex) begin err_cnt++; $display("FAIL b2b_byte: got %h exp %h", got, ex); end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_controller_reply();
        test_start_end();
        test_bit_alternation();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
